bsg_manycore_packet_sender: RTL and testbench
=============================================

Name: bsg_manycore_packet_sender

Overview:
Host-side transmitter that injects remote-store packets into a manycore I/O channel. The packets use the same format as the I/O monitor decodes: op, addr, data, y_cord, x_cord, packed MSB to LSB.
- A single command streams count words from a local read-only memory to consecutive word addresses in one destination tile.
- After the last data word, it sends one "go" packet to that tile.
- Used by testbenches and the loader to program tiles and release them.

Parameters:
xcord_width_p, "inv", x coordinate width
ycord_width_p, "inv", y coordinate width
addr_width_p, "inv", remote word-address width
data_width_p, "inv", data width
count_width_p, 16, width of word count and memory address
op_store_p, 6'd1, opcode placed in every emitted packet
go_addr_p, 'hBEEF, remote address of the terminal go packet (truncated to addr_width_p)
packet_width_lp, 6+xcord_width_p+ycord_width_p+addr_width_p+data_width_p, packet width (derived)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, synchronous, active-low
cmd_v_i  in  1  command valid
cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
cmd_x_i  in  xcord_width_p  destination x
cmd_y_i  in  ycord_width_p  destination y
cmd_addr_i  in  addr_width_p  first remote word address
cmd_count_i  in  count_width_p  number of data words (0 allowed)
mem_v_o  out  1  memory read strobe
mem_addr_o  out  count_width_p  memory word index
mem_data_i  in  data_width_p  read data, valid the cycle after mem_v_o
v_o  out  1  packet valid
data_o  out  packet_width_lp  packet
ready_i  in  1  channel ready; transfer when v_o & ready_i
done_o  out  1  one-cycle pulse after the go packet transfers
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk_i; synchronous active-low reset reset_n_i.
- Reset (reset_n_i==0 at posedge): state IDLE; v_o=0, mem_v_o=0, done_o=0, busy_o=0, cmd_ready_o=0 during reset; all counters 0. Reset mid-operation abandons the command; the next packet is not emitted.
- cmd_ready_o=1 only in IDLE (after reset released).
- IDLE: on command accept, latch x, y, addr, count; clear word index i to 0. If count==0 go to GO, else go to FETCH.
- FETCH (1 cycle): mem_v_o=1, mem_addr_o=i. Go to LOAD.
- LOAD (1 cycle): capture mem_data_i into the hold register. Go to SEND.
- SEND: v_o=1; data_o={op_store_p, addr_r+i (mod 2^addr_width_p), hold, y_r, x_r}. data_o stays stable while ready_i=0. On transfer, i<=i+1; if i+1==count go to GO, else go to FETCH.
- GO: v_o=1; data_o={op_store_p, go_addr_p, data={y_r zero-extended to 16b, x_r zero-extended to 16b} truncated/padded to data_width_p, y_r, x_r}. On transfer go to DONE.
- DONE (1 cycle): done_o=1, then IDLE. A new command can be accepted the cycle after DONE.
- mem_addr_o holds its last value when mem_v_o=0. v_o never drops without a transfer, except on reset.
- Throughput: at most 1 packet per 3 cycles with ready_i held high. Latency from command accept to first v_o = 3 cycles.
- count = 2^count_width_p - 1 is legal; i never wraps inside a command.
- Remote address increments by 1 per word and wraps modulo 2^addr_width_p.

Optional Feature:
BSG_MANYCORE_PACKET_SENDER_TRACE_EN
- Defined: non-synthesizable $display on each packet transfer: "## SEND x,y=%d,%d addr %x data %x", with "GO" tagged for the terminal packet. Also a $display on done_o.
- Undefined: no display code compiled; functionally identical.

Test Plan:
- Reset, then cmd x=2,y=1,addr=0x100,count=3, mem[0..2]=A,B,C, ready_i=1 -> three packets at addr 0x100/0x101/0x102 with data A/B/C, then GO at go_addr_p with data 0x0001_0002; first v_o 3 cycles after accept; done_o pulse; 11 cycles from accept to done.
- count=0 -> cycle after accept v_o with the GO packet only; no mem_v_o; done_o follows the transfer.
- Same command as the first test with ready_i low for 5 cycles on the second packet -> data_o stable, v_o held; no extra mem_v_o; the sequence completes unchanged.
- addr=2^addr_width_p-1, count=2 -> second packet addr 0 (wrap).
- reset_n_i low during the second SEND -> v_o=0 next cycle; busy_o=0; cmd_ready_o=1 after release; new command runs from word 0.
- cmd_v_i asserted while busy -> not accepted (cmd_ready_o=0); accepted the cycle after done_o.

Source files
------------

// File: rtl/bsg_manycore_packet_sender.sv
// Host-side remote-store packet transmitter for a manycore I/O channel.
// One command streams cmd_count_i words from a local ROM to consecutive
// remote word addresses in one tile, then sends a terminal "go" packet.
// Packet layout, MSB to LSB: {op, addr, data, y_cord, x_cord}.
// Ports:
//   clk_i, reset_n_i           clock, synchronous active-low reset
//   cmd_v_i/cmd_ready_o        command handshake (x, y, addr, count)
//   mem_v_o/mem_addr_o         ROM read strobe and word index
//   mem_data_i                 ROM data, valid the cycle after mem_v_o
//   v_o/data_o/ready_i         packet channel, transfer on v_o & ready_i
//   done_o                     one-cycle pulse after the go packet
//   busy_o                     high whenever not idle
// Optional: define BSG_MANYCORE_PACKET_SENDER_TRACE_EN for transfer trace.
module bsg_manycore_packet_sender #(
   parameter int          xcord_width_p   = 4,
   parameter int          ycord_width_p   = 4,
   parameter int          addr_width_p    = 12,
   parameter int          data_width_p    = 32,
   parameter int          count_width_p   = 16,
   parameter logic [5:0]  op_store_p      = 6'd1,
   parameter int          go_addr_p       = 'hBEEF,
   parameter int          packet_width_lp = 6 + xcord_width_p + ycord_width_p
                                            + addr_width_p + data_width_p
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       cmd_v_i,
   output logic                       cmd_ready_o,
   input  logic [xcord_width_p-1:0]   cmd_x_i,
   input  logic [ycord_width_p-1:0]   cmd_y_i,
   input  logic [addr_width_p-1:0]    cmd_addr_i,
   input  logic [count_width_p-1:0]   cmd_count_i,
   output logic                       mem_v_o,
   output logic [count_width_p-1:0]   mem_addr_o,
   input  logic [data_width_p-1:0]    mem_data_i,
   output logic                       v_o,
   output logic [packet_width_lp-1:0] data_o,
   input  logic                       ready_i,
   output logic                       done_o,
   output logic                       busy_o
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] SEND  = 3'd3;
   localparam logic [2:0] GO    = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [addr_width_p-1:0] go_addr_lp = addr_width_p'(go_addr_p);

   logic [2:0]               state_q, state_d;
   logic [xcord_width_p-1:0] x_q, x_d;
   logic [ycord_width_p-1:0] y_q, y_d;
   logic [addr_width_p-1:0]  addr_q, addr_d;
   logic [count_width_p-1:0] count_q, count_d;
   logic [count_width_p-1:0] i_q, i_d;
   logic [count_width_p-1:0] maddr_q, maddr_d;
   logic [data_width_p-1:0]  hold_q, hold_d;

   logic                     xfer;
   logic                     last_word;
   logic [count_width_p:0]   i_inc;
   logic [addr_width_p-1:0]  send_addr;
   logic [31:0]              go_word;
   logic [data_width_p-1:0]  go_data;

   // One extra bit so count = 2^count_width_p-1 compares without wrap.
   assign i_inc     = {1'b0, i_q} + 1'b1;
   assign last_word = (i_inc == {1'b0, count_q});
   assign send_addr = addr_q + addr_width_p'(i_q);
   assign go_word   = {16'(y_q), 16'(x_q)};
   assign go_data   = data_width_p'(go_word);

   // Outputs are forced low while reset is held.
   assign cmd_ready_o = reset_n_i & (state_q == IDLE);
   assign busy_o      = reset_n_i & (state_q != IDLE);
   assign mem_v_o     = reset_n_i & (state_q == FETCH);
   assign done_o      = reset_n_i & (state_q == DONE);
   assign v_o         = reset_n_i & ((state_q == SEND) | (state_q == GO));
   assign xfer        = v_o & ready_i;

   // Index is presented live during FETCH, otherwise the last one is held.
   assign mem_addr_o = (state_q == FETCH) ? i_q : maddr_q;

   always_comb begin
      data_o = {op_store_p, send_addr, hold_q, y_q, x_q};
      if (state_q == GO) begin
         data_o = {op_store_p, go_addr_lp, go_data, y_q, x_q};
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      addr_d  = addr_q;
      count_d = count_q;
      i_d     = i_q;
      maddr_d = maddr_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_v_i) begin
               x_d     = cmd_x_i;
               y_d     = cmd_y_i;
               addr_d  = cmd_addr_i;
               count_d = cmd_count_i;
               i_d     = '0;
               state_d = (cmd_count_i == '0) ? GO : FETCH;
            end
         end
         FETCH: begin
            maddr_d = i_q;
            state_d = LOAD;
         end
         LOAD: begin
            hold_d  = mem_data_i;
            state_d = SEND;
         end
         SEND: begin
            if (xfer) begin
               i_d     = i_inc[count_width_p-1:0];
               state_d = last_word ? GO : FETCH;
            end
         end
         GO: begin
            if (xfer) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         addr_q  <= '0;
         count_q <= '0;
         i_q     <= '0;
         maddr_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         i_q     <= i_d;
         maddr_q <= maddr_d;
         hold_q  <= hold_d;
      end
   end

`ifdef BSG_MANYCORE_PACKET_SENDER_TRACE_EN
   always_ff @(posedge clk_i) begin
      if (reset_n_i && xfer && state_q == GO) begin
         $display("## SEND GO x,y=%d,%d addr %x data %x",
                  x_q, y_q, go_addr_lp, go_data);
      end else if (reset_n_i && xfer) begin
         $display("## SEND x,y=%d,%d addr %x data %x",
                  x_q, y_q, send_addr, hold_q);
      end
      if (done_o) begin
         $display("## DONE x,y=%d,%d", x_q, y_q);
      end
   end
`endif

endmodule

// File: tb/tb_bsg_manycore_packet_sender.sv
// Self-checking bench for bsg_manycore_packet_sender.
// Expected packet stream is built per command from a queue model.
module tb_bsg_manycore_packet_sender;

   localparam int XW = 4;
   localparam int YW = 4;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam int PW = 6 + XW + YW + AW + DW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_v;
   logic          cmd_ready;
   logic [XW-1:0] cmd_x;
   logic [YW-1:0] cmd_y;
   logic [AW-1:0] cmd_addr;
   logic [CW-1:0] cmd_count;
   logic          mem_v;
   logic [CW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          v_o;
   logic [PW-1:0] data_o;
   logic          ready;
   logic          done;
   logic          busy;

   bsg_manycore_packet_sender #(
      .xcord_width_p(XW),
      .ycord_width_p(YW),
      .addr_width_p (AW),
      .data_width_p (DW),
      .count_width_p(CW)
   ) dut (
      .clk_i      (clk),
      .reset_n_i  (rst_n),
      .cmd_v_i    (cmd_v),
      .cmd_ready_o(cmd_ready),
      .cmd_x_i    (cmd_x),
      .cmd_y_i    (cmd_y),
      .cmd_addr_i (cmd_addr),
      .cmd_count_i(cmd_count),
      .mem_v_o    (mem_v),
      .mem_addr_o (mem_addr),
      .mem_data_i (mem_data),
      .v_o        (v_o),
      .data_o     (data_o),
      .ready_i    (ready),
      .done_o     (done),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [0:15];
   always @(posedge clk) begin
      if (mem_v) mem_data <= mem[mem_addr[3:0]];
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic fail_now(input string nm);
      total_cnt++;
      $display("FAIL %s: bound expired or event missing", nm);
   endtask

   function automatic logic [PW-1:0] mk(input int a, input int d,
                                        input int y, input int x);
      logic [5:0] op;
      op = 6'd1;
      return {op, AW'(a), DW'(d), YW'(y), XW'(x)};
   endfunction

   logic [PW-1:0] exp_q [$];

   task automatic push_cmd(input int x, input int y, input int a,
                           input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(mk(a + k, mem[k], y, x));
      exp_q.push_back(mk('hBEEF, y * 65536 + x, y, x));
   endtask

   int            memv_cnt;
   int            xfer_cnt;
   int            done_seen;
   int            acc_cnt = 0;
   int            accept_cyc;
   int            first_v_cyc;
   int            done_cyc;
   logic [CW-1:0] last_maddr;
   logic          prev_v = 1'b0;
   logic          prev_x = 1'b0;
   logic [PW-1:0] prev_d;
   logic [PW-1:0] first_pkt;
   logic [PW-1:0] pkt2;
   logic [PW-1:0] last_pkt;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         last_maddr = '0;
         prev_v = 1'b0;
      end else begin
         if (cmd_v && cmd_ready) begin
            acc_cnt++;
            accept_cyc = cyc;
         end
         if (v_o && first_v_cyc < 0) first_v_cyc = cyc;
         if (prev_v && !prev_x) begin
            check("hold_v", 64'(v_o), 64'd1);
            check("hold_data", 64'(data_o), 64'(prev_d));
         end
         if (mem_v) begin
            check("mem_addr", 64'(mem_addr), 64'(memv_cnt));
            memv_cnt++;
            last_maddr = mem_addr;
         end else begin
            check("mem_hold", 64'(mem_addr), 64'(last_maddr));
         end
         if (v_o && ready) begin
            if (exp_q.size() == 0) fail_now("pkt_extra");
            else check("pkt", 64'(data_o), 64'(exp_q.pop_front()));
            xfer_cnt++;
            if (xfer_cnt == 1) first_pkt = data_o;
            if (xfer_cnt == 2) pkt2 = data_o;
            last_pkt = data_o;
         end
         if (done) begin
            done_seen++;
            done_cyc = cyc;
         end
         prev_v = v_o;
         prev_x = v_o && ready;
         prev_d = data_o;
      end
   end

   task automatic clr_stats();
      memv_cnt = 0;
      xfer_cnt = 0;
      done_seen = 0;
      first_v_cyc = -1;
   endtask

   task automatic issue(input int x, input int y, input int a,
                        input int n);
      @(posedge clk); #1;
      cmd_v = 1'b1;
      cmd_x = XW'(x);
      cmd_y = YW'(y);
      cmd_addr = AW'(a);
      cmd_count = CW'(n);
   endtask

   task automatic wait_accept();
      bit ok;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_now("accept");
      @(posedge clk); #1;
   endtask

   task automatic run_cmd(input int x, input int y, input int a,
                          input int n, input int stall_len);
      int  stall_left;
      bit  ok;
      push_cmd(x, y, a, n);
      clr_stats();
      stall_left = stall_len;
      ready = 1'b1;
      issue(x, y, a, n);
      wait_accept();
      cmd_v = 1'b0;
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         ready = 1'b1;
         if (v_o && xfer_cnt == 1 && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
         end
         if (done_seen > 0) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) fail_now("done_timeout");
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("q_empty", 64'(exp_q.size()), 64'd0);
      check("memv_cnt", 64'(memv_cnt), 64'(n));
      check("done_once", 64'(done_seen), 64'd1);
      check("lat_first_v", 64'(first_v_cyc - accept_cyc),
            64'((n == 0) ? 1 : 3));
      check("lat_done", 64'(done_cyc - accept_cyc),
            64'(3 * n + 2 + stall_len));
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_ready", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      bit ok;
      mem[0] = 32'hAAAA_0001;
      mem[1] = 32'hBBBB_0002;
      mem[2] = 32'hCCCC_0003;
      for (int k = 3; k < 16; k++) mem[k] = 32'h1111_1111 * k;
      rst_n = 1'b0;
      cmd_v = 1'b0;
      cmd_x = '0;
      cmd_y = '0;
      cmd_addr = '0;
      cmd_count = '0;
      ready = 1'b1;
      clr_stats();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_v", 64'(v_o), 64'd0);
      check("rst_memv", 64'(mem_v), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ready", 64'(cmd_ready), 64'd1);
      check("rel_maddr", 64'(mem_addr), 64'd0);

      // Basic three-word command.
      run_cmd(2, 1, 'h100, 3, 0);
      check("t1_first_pkt", 64'(first_pkt),
            64'({6'd1, 12'h100, 32'hAAAA_0001, 4'd1, 4'd2}));
      check("t1_go_pkt", 64'(last_pkt),
            64'({6'd1, 12'hEEF, 32'h0001_0002, 4'd1, 4'd2}));

      // Zero-length command sends only the go packet.
      run_cmd(5, 6, 'h40, 0, 0);
      check("t2_go_pkt", 64'(last_pkt),
            64'({6'd1, 12'hEEF, 32'h0006_0005, 4'd6, 4'd5}));

      // Back-pressure on the second packet.
      run_cmd(2, 1, 'h100, 3, 5);
      check("t3_pkt2", 64'(pkt2),
            64'({6'd1, 12'h101, 32'hBBBB_0002, 4'd1, 4'd2}));

      // Remote address wrap.
      run_cmd(7, 3, 'hFFF, 2, 0);
      check("t4_wrap_addr", 64'(pkt2[51:40]), 64'h000);
      check("t4_first_addr", 64'(first_pkt[51:40]), 64'hFFF);

      // Reset during the second SEND.
      push_cmd(2, 1, 'h100, 3);
      clr_stats();
      ready = 1'b1;
      issue(2, 1, 'h100, 3);
      wait_accept();
      cmd_v = 1'b0;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         if (v_o && xfer_cnt == 1) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) fail_now("t5_second_send");
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_rst_v", 64'(v_o), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_v_after", 64'(v_o), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_ready", 64'(cmd_ready), 64'd1);
      check("t5_busy_rel", 64'(busy), 64'd0);
      run_cmd(2, 1, 'h100, 3, 0);
      check("t5_restart_pkt", 64'(first_pkt),
            64'({6'd1, 12'h100, 32'hAAAA_0001, 4'd1, 4'd2}));

      // Command held high while busy.
      push_cmd(3, 2, 'h10, 1);
      push_cmd(1, 3, 'h20, 0);
      clr_stats();
      ready = 1'b1;
      acc_cnt = 0;
      issue(3, 2, 'h10, 1);
      wait_accept();
      cmd_x = 4'd1;
      cmd_y = 4'd3;
      cmd_addr = 12'h20;
      cmd_count = 16'd0;
      @(negedge clk);
      check("t6_not_ready", 64'(cmd_ready), 64'd0);
      check("t6_busy", 64'(busy), 64'd1);
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (acc_cnt == 2) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_now("t6_second_accept");
      cmd_v = 1'b0;
      check("t6_acc_after_done", 64'(accept_cyc - done_cyc), 64'd1);
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         if (done_seen == 2) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) fail_now("t6_done");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t6_q_empty", 64'(exp_q.size()), 64'd0);
      check("t6_memv", 64'(memv_cnt), 64'd1);
      check("t6_go_pkt", 64'(last_pkt),
            64'({6'd1, 12'hEEF, 32'h0003_0001, 4'd3, 4'd1}));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
